jtag_tap_sync: RTL and testbench

Synchronous IEEE 1149.1 TAP controller that consumes the tck/tms/tdi pins driven by `jtag_dpi` and returns tdo to it. It oversamples all JTAG pins in the sys_clk domain, so no logic is clocked by tck. It implements the 16-state TAP FSM, a 4-bit instruction register, and IDCODE, BYPASS and an 8-bit USER data register. The USER register is exposed to the rest of the design as a parallel output.

---
 rtl/jtag_tap_sync.sv | 158 +++++++++++++++
 tb/tb_jtag_tap_sync.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_sync.sv
// IEEE 1149.1 TAP controller oversampled in the sys_clk domain.
// IR, IDCODE/BYPASS/USER data registers; USER exposed in parallel.
module jtag_tap_sync #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] IDCODE      = 32'h1000_563D,
  parameter logic [7:0]  USER_RST    = 8'h38
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       tck,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  output logic [7:0] user_q,
  output logic       user_upd,
  output logic [3:0] tap_state
);

  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_e;

  localparam logic [3:0] I_IDCODE = 4'b0001;
  localparam logic [3:0] I_USER   = 4'b1000;

  logic [SYNC_STAGES-1:0] tck_q, tms_q, tdi_q;
  logic                   tck_d_q;
  logic                   tck_s, tms_s, tdi_s;
  logic                   rise, fall;

  tap_e        state_q, state_d;
  logic [3:0]  ir_q, ir_sr_q;
  logic [31:0] dr_sr_q, dr_cap, dr_shift;
  logic [7:0]  usr_q;
  logic        upd_q, tdo_q;
  logic        sel_id, sel_usr, sel_byp;

  assign tck_s = tck_q[SYNC_STAGES-1];
  assign tms_s = tms_q[SYNC_STAGES-1];
  assign tdi_s = tdi_q[SYNC_STAGES-1];
  assign rise  = tck_s & ~tck_d_q;
  assign fall  = ~tck_s & tck_d_q;

  // All three pins share one chain depth so tms/tdi stay aligned to tck.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_q   <= '0;
      tms_q   <= '0;
      tdi_q   <= '0;
      tck_d_q <= 1'b0;
    end else begin
      tck_q   <= {tck_q[SYNC_STAGES-2:0], tck};
      tms_q   <= {tms_q[SYNC_STAGES-2:0], tms};
      tdi_q   <= {tdi_q[SYNC_STAGES-2:0], tdi};
      tck_d_q <= tck_s;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:      state_d = tms_s ? TLR      : RTI;
      RTI:      state_d = tms_s ? SEL_DR   : RTI;
      SEL_DR:   state_d = tms_s ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = tms_s ? EX1_DR   : SH_DR;
      SH_DR:    state_d = tms_s ? EX1_DR   : SH_DR;
      EX1_DR:   state_d = tms_s ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = tms_s ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_d = tms_s ? UPD_DR   : SH_DR;
      UPD_DR:   state_d = tms_s ? SEL_DR   : RTI;
      SEL_IR:   state_d = tms_s ? TLR      : CAP_IR;
      CAP_IR:   state_d = tms_s ? EX1_IR   : SH_IR;
      SH_IR:    state_d = tms_s ? EX1_IR   : SH_IR;
      EX1_IR:   state_d = tms_s ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = tms_s ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_d = tms_s ? UPD_IR   : SH_IR;
      UPD_IR:   state_d = tms_s ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

  assign sel_id  = (ir_q == I_IDCODE);
  assign sel_usr = (ir_q == I_USER);
  assign sel_byp = ~sel_id & ~sel_usr;

  // Shared DR: IDCODE uses 32 bits, USER 8, BYPASS only bit 0.
  always_comb begin
    dr_cap   = '0;
    dr_shift = dr_sr_q;
    unique case (1'b1)
      sel_id: begin
        dr_cap   = IDCODE;
        dr_shift = {tdi_s, dr_sr_q[31:1]};
      end
      sel_usr: begin
        dr_cap        = {24'b0, usr_q};
        dr_shift[7:0] = {tdi_s, dr_sr_q[7:1]};
      end
      sel_byp: begin
        dr_cap      = '0;
        dr_shift[0] = tdi_s;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TLR;
      ir_q    <= I_IDCODE;
      ir_sr_q <= '0;
      dr_sr_q <= '0;
      usr_q   <= USER_RST;
      upd_q   <= 1'b0;
      tdo_q   <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (rise) begin
        state_q <= state_d;
        if (state_q == CAP_IR) ir_sr_q <= 4'b0101;
        if (state_q == SH_IR)  ir_sr_q <= {tdi_s, ir_sr_q[3:1]};
        if (state_q == CAP_DR) dr_sr_q <= dr_cap;
        if (state_q == SH_DR)  dr_sr_q <= dr_shift;
      end
      if (fall) begin
        if (state_q == UPD_IR) ir_q <= ir_sr_q;
        if (state_q == UPD_DR && sel_usr) begin
          usr_q <= dr_sr_q[7:0];
          upd_q <= 1'b1;
        end
        if (state_q == SH_IR)      tdo_q <= ir_sr_q[0];
        else if (state_q == SH_DR) tdo_q <= dr_sr_q[0];
        else                       tdo_q <= 1'b0;
      end
      if (state_q == TLR) ir_q <= I_IDCODE;
    end
  end

  assign tdo       = tdo_q;
  assign user_q    = usr_q;
  assign user_upd  = upd_q;
  assign tap_state = state_q;

endmodule

// File: tb/tb_jtag_tap_sync.sv
// Bench for jtag_tap_sync: directed test plan plus random tms/tdi
// traffic compared against a queue-based TAP reference model.
module tb_jtag_tap_sync;

  localparam int S  = 2;
  localparam int PH = S + 4;

  logic       sys_clk = 1'b0;
  logic       rst_n, tck, tms, tdi;
  logic       tdo, user_upd;
  logic [7:0] user_q;
  logic [3:0] tap_state;

  jtag_tap_sync #(
    .SYNC_STAGES(S),
    .IDCODE(32'h1000_563D),
    .USER_RST(8'h38)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .tck(tck),
    .tms(tms),
    .tdi(tdi),
    .tdo(tdo),
    .user_q(user_q),
    .user_upd(user_upd),
    .tap_state(tap_state)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;
  int upd_seen = 0;

  always @(posedge sys_clk) if (user_upd === 1'b1) upd_seen++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: TAP graph as lookup tables, registers as bit queues
  int         m_st;
  bit         m_irq[$];
  bit         m_drq[$];
  logic [3:0] m_ir;
  logic [7:0] m_user;
  int         m_upd = 0;
  logic       m_tdo;

  function automatic int nxt(input int s, input bit t);
    int n0[16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int n1[16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};
    return t ? n1[s] : n0[s];
  endfunction

  function automatic logic [31:0] qval(input bit q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction

  task automatic model_reset();
    m_st   = 15;
    m_ir   = 4'b0001;
    m_irq  = {1'b0, 1'b0, 1'b0, 1'b0};
    m_drq.delete();
    m_user = 8'h38;
    m_tdo  = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit d);
    logic [31:0] cv;
    int          w;
    case (m_st)
      14: m_irq = {1'b1, 1'b0, 1'b1, 1'b0};
      10: begin void'(m_irq.pop_front()); m_irq.push_back(d); end
      6: begin
        if (m_ir == 4'b0001)      begin w = 32; cv = 32'h1000_563D; end
        else if (m_ir == 4'b1000) begin w = 8;  cv = {24'b0, m_user}; end
        else                      begin w = 1;  cv = '0; end
        m_drq.delete();
        for (int i = 0; i < w; i++) m_drq.push_back(cv[i]);
      end
      2: begin void'(m_drq.pop_front()); m_drq.push_back(d); end
      default: ;
    endcase
    m_st = nxt(m_st, t);
    if (m_st == 15) m_ir = 4'b0001;
    if (m_st == 13) begin
      cv   = qval(m_irq);
      m_ir = cv[3:0];
    end
    if (m_st == 5 && m_ir == 4'b1000) begin
      cv     = qval(m_drq);
      m_user = cv[7:0];
      m_upd++;
    end
    if (m_st == 10)     m_tdo = m_irq[0];
    else if (m_st == 2) m_tdo = m_drq[0];
    else                m_tdo = 1'b0;
  endtask

  task automatic tck_cycle(input bit t, input bit d);
    @(negedge sys_clk);
    tms = t;
    tdi = d;
    repeat (2) @(negedge sys_clk);
    tck = 1'b1;
    repeat (PH) @(negedge sys_clk);
    tck = 1'b0;
    repeat (PH) @(negedge sys_clk);
    model_step(t, d);
    chk("state", {28'b0, tap_state}, m_st);
    chk("tdo", {31'b0, tdo}, {31'b0, m_tdo});
    chk("user_q", {24'b0, user_q}, {24'b0, m_user});
    chk("upd_cnt", upd_seen, m_upd);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rst_n = 1'b0;
    tck   = 1'b0;
    repeat (3) @(negedge sys_clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic goto_shdr();
    tck_cycle(1, 0);
    tck_cycle(0, 0);
    tck_cycle(0, 0);
  endtask

  task automatic goto_shir();
    tck_cycle(1, 0);
    tck_cycle(1, 0);
    tck_cycle(0, 0);
    tck_cycle(0, 0);
  endtask

  task automatic finish_upd();
    tck_cycle(1, 0);
    tck_cycle(0, 0);
  endtask

  task automatic shift(input int n, input logic [31:0] data,
                       output logic [31:0] out);
    out = '0;
    for (int i = 0; i < n; i++) begin
      out[i] = tdo;
      tck_cycle(i == n - 1, data[i]);
    end
  endtask

  task automatic load_ir(input logic [3:0] v, output logic [3:0] cap);
    logic [31:0] o;
    goto_shir();
    shift(4, {28'b0, v}, o);
    cap = o[3:0];
    finish_upd();
  endtask

  logic [31:0] o;
  logic [3:0]  c;
  int          base;

  initial begin
    rst_n = 1'b0;
    tck   = 1'b0;
    tms   = 1'b0;
    tdi   = 1'b0;
    model_reset();
    do_reset();
    chk("rst_state", {28'b0, tap_state}, 32'hF);
    chk("rst_tdo", {31'b0, tdo}, 32'h0);
    chk("rst_user", {24'b0, user_q}, 32'h38);
    chk("rst_upd", {31'b0, user_upd}, 32'h0);

    for (int i = 0; i < 5; i++) tck_cycle(1, i[0]);
    chk("tlr_state", {28'b0, tap_state}, 32'hF);
    chk("tlr_user", {24'b0, user_q}, 32'h38);

    tck_cycle(0, 0);
    goto_shdr();
    shift(32, 32'h0, o);
    chk("idcode", o, 32'h1000_563D);
    finish_upd();

    load_ir(4'b1111, c);
    chk("ir_capture", {28'b0, c}, 32'h5);
    goto_shdr();
    shift(4, 32'hD, o);
    chk("bypass", o, 32'hA);
    finish_upd();

    load_ir(4'b1000, c);
    base = upd_seen;
    goto_shdr();
    shift(8, 32'hA5, o);
    chk("user_out", o, 32'h38);
    finish_upd();
    chk("user_pulses", upd_seen - base, 1);
    chk("user_val", {24'b0, user_q}, 32'hA5);

    load_ir(4'b1000, c);
    base = upd_seen;
    goto_shdr();
    for (int i = 0; i < 3; i++) tck_cycle(0, 1);
    do_reset();
    chk("abort_state", {28'b0, tap_state}, 32'hF);
    chk("abort_user", {24'b0, user_q}, 32'h38);
    chk("abort_upd", upd_seen - base, 0);
    tck_cycle(0, 0);
    goto_shdr();
    shift(32, 32'h0, o);
    chk("idcode2", o, 32'h1000_563D);
    finish_upd();

    for (int i = 0; i < 400; i++) begin
      tck_cycle($urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        chk("rnd_rst", {28'b0, tap_state}, 32'hF);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
